play_button_debouncer: RTL



---
 rtl/play_button_debouncer.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/play_button_debouncer.sv
// -----------------------------------------------------------------------------
// play_button_debouncer
//
// Conditions the raw play/pause pushbutton before it reaches the Nios
// play-input PIO. The asynchronous key is polarity-corrected, synchronised
// through two flops, then qualified by a restartable debounce FSM. A clean
// pressed level feeds the PIO; single-cycle strobes mark press, release and
// long-press events. play_state toggles on each short press and is forced
// to 0 (stopped) by a long press.
//
// Parameters:
//   DEBOUNCE_CYCLES  stable synchronised samples needed after the first
//                    changed sample (>= 2)
//   LONG_CYCLES      HELD-state cycles before long_press fires (>= 2)
//   ACTIVE_LOW       1: key_in low means pressed; 0: key_in high means pressed
//
// Ports:
//   clk            in   system clock
//   reset          in   asynchronous, active-high reset
//   key_in         in   raw pushbutton, asynchronous and bouncy
//   btn_level      out  debounced pressed level (1 = pressed), to PIO in_port
//   press_pulse    out  one-cycle strobe on debounced press
//   release_pulse  out  one-cycle strobe on debounced release
//   long_press     out  one-cycle strobe, at most once per press
//   play_state     out  1 = playing, 0 = paused/stopped
// -----------------------------------------------------------------------------
module play_button_debouncer #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned LONG_CYCLES     = 50000000,
    parameter int unsigned ACTIVE_LOW      = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic key_in,
    output logic btn_level,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_press,
    output logic play_state
);

    localparam int unsigned DEB_W  = $clog2(DEBOUNCE_CYCLES);
    localparam int unsigned HOLD_W = $clog2(LONG_CYCLES);

    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);

    typedef enum logic [1:0] {
        S_RELEASED   = 2'd0,
        S_PRESS_PEND = 2'd1,
        S_HELD       = 2'd2,
        S_REL_PEND   = 2'd3
    } state_t;

    // -------------------------------------------------------------------------
    // Registers and next-state wires
    // -------------------------------------------------------------------------
    logic              r_sync_meta;
    logic              r_sync_s;

    state_t            r_state;
    state_t            w_state_nxt;

    logic [DEB_W-1:0]  r_deb_cnt;
    logic [DEB_W-1:0]  w_deb_cnt_nxt;
    logic [HOLD_W-1:0] r_hold_cnt;
    logic [HOLD_W-1:0] w_hold_cnt_nxt;
    logic              r_long_done;
    logic              w_long_done_nxt;

    logic              r_btn_level;
    logic              w_btn_level_nxt;
    logic              r_press_pulse;
    logic              w_press_pulse_nxt;
    logic              r_release_pulse;
    logic              w_release_pulse_nxt;
    logic              r_long_press;
    logic              w_long_press_nxt;
    logic              r_play_state;
    logic              w_play_state_nxt;

    logic              w_key_pressed;
    logic              w_hold_advance;

    // Polarity correction ahead of the synchroniser so the synchronised
    // sample is always 1 = pressed.
    assign w_key_pressed = (ACTIVE_LOW != 0) ? ~key_in : key_in;

    // -------------------------------------------------------------------------
    // Two-flop synchroniser
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync_meta <= 1'b0;
            r_sync_s    <= 1'b0;
        end else begin
            r_sync_meta <= w_key_pressed;
            r_sync_s    <= r_sync_meta;
        end
    end

    // -------------------------------------------------------------------------
    // FSM state, counters and registered outputs
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state         <= S_RELEASED;
            r_deb_cnt       <= '0;
            r_hold_cnt      <= '0;
            r_long_done     <= 1'b0;
            r_btn_level     <= 1'b0;
            r_press_pulse   <= 1'b0;
            r_release_pulse <= 1'b0;
            r_long_press    <= 1'b0;
            r_play_state    <= 1'b0;
        end else begin
            r_state         <= w_state_nxt;
            r_deb_cnt       <= w_deb_cnt_nxt;
            r_hold_cnt      <= w_hold_cnt_nxt;
            r_long_done     <= w_long_done_nxt;
            r_btn_level     <= w_btn_level_nxt;
            r_press_pulse   <= w_press_pulse_nxt;
            r_release_pulse <= w_release_pulse_nxt;
            r_long_press    <= w_long_press_nxt;
            r_play_state    <= w_play_state_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and output logic
    // -------------------------------------------------------------------------
    always_comb begin
        w_state_nxt         = r_state;
        w_deb_cnt_nxt       = r_deb_cnt;
        w_hold_cnt_nxt      = r_hold_cnt;
        w_long_done_nxt     = r_long_done;
        w_btn_level_nxt     = r_btn_level;
        w_press_pulse_nxt   = 1'b0;
        w_release_pulse_nxt = 1'b0;
        w_long_press_nxt    = 1'b0;
        w_play_state_nxt    = r_play_state;
        w_hold_advance      = 1'b0;

        case (r_state)
            S_RELEASED: begin
                if (r_sync_s) begin
                    w_state_nxt   = S_PRESS_PEND;
                    w_deb_cnt_nxt = '0;
                end
            end

            S_PRESS_PEND: begin
                if (!r_sync_s) begin
                    w_state_nxt = S_RELEASED;
                end else if (r_deb_cnt == DEB_LAST) begin
                    w_state_nxt       = S_HELD;
                    w_btn_level_nxt   = 1'b1;
                    w_press_pulse_nxt = 1'b1;
                    w_hold_cnt_nxt    = '0;
                    w_long_done_nxt   = 1'b0;
                end else begin
                    w_deb_cnt_nxt = r_deb_cnt + DEB_W'(1);
                end
            end

            S_HELD: begin
                if (r_sync_s) begin
                    w_hold_advance = 1'b1;
                end else begin
                    w_state_nxt   = S_REL_PEND;
                    w_deb_cnt_nxt = '0;
                end
            end

            S_REL_PEND: begin
                if (r_sync_s) begin
                    // A release bounce counts as a held cycle on the edge it
                    // returns to HELD, so the hold timer is frozen only for
                    // the cycles that actually sampled the key released.
                    w_state_nxt    = S_HELD;
                    w_hold_advance = 1'b1;
                end else if (r_deb_cnt == DEB_LAST) begin
                    w_state_nxt         = S_RELEASED;
                    w_btn_level_nxt     = 1'b0;
                    w_release_pulse_nxt = 1'b1;
                    if (!r_long_done) begin
                        w_play_state_nxt = ~r_play_state;
                    end
                end else begin
                    w_deb_cnt_nxt = r_deb_cnt + DEB_W'(1);
                end
            end

            default: begin
                w_state_nxt = S_RELEASED;
            end
        endcase

        // Hold timer: fires long_press once, then stops counting for the
        // rest of this press.
        if (w_hold_advance && !r_long_done) begin
            if (r_hold_cnt == HOLD_LAST) begin
                w_long_press_nxt = 1'b1;
                w_long_done_nxt  = 1'b1;
                w_play_state_nxt = 1'b0;
            end else begin
                w_hold_cnt_nxt = r_hold_cnt + HOLD_W'(1);
            end
        end
    end

    assign btn_level     = r_btn_level;
    assign press_pulse   = r_press_pulse;
    assign release_pulse = r_release_pulse;
    assign long_press    = r_long_press;
    assign play_state    = r_play_state;

endmodule
